// File: rtl/gpio_cmd_master.sv
// Command master that drives a GPIO file-register word: strobes opcode/payload with an
// enable bit, then optionally captures one or two response words at fixed latencies.
module gpio_cmd_master #(
  parameter int NB_WORD    = 32,
  parameter int STROBE_CYC = 2,
  parameter int RESP_LAT   = 2,
  parameter int HI_LAT     = 2,
  parameter int GAP_CYC    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [7:0]           i_req_opcode,
  input  logic [22:0]          i_req_data,
  input  logic                 i_req_read,
  input  logic                 i_req_wide,
  output logic [NB_WORD-1:0]   o_cmd_word,
  input  logic [NB_WORD-1:0]   i_rsp_word,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [2*NB_WORD-1:0] o_rsp_data,
  output logic                 o_busy
);

  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  localparam int S_EFF = at_least_one(STROBE_CYC);
  localparam int R_EFF = at_least_one(RESP_LAT);
  localparam int H_EFF = at_least_one(HI_LAT);
  localparam int G_EFF = at_least_one(GAP_CYC);
  localparam int MAX_A = (S_EFF > R_EFF) ? S_EFF : R_EFF;
  localparam int MAX_B = (H_EFF > G_EFF) ? H_EFF : G_EFF;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, WAIT_LO, WAIT_HI, RESP, GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cyc_cnt_q;
  logic [CNT_W-1:0]       lat_cnt_q;
  logic                   lo_done_q, hi_done_q;
  logic                   rd_q, wide_q, rst_done_q;
  logic [7:0]             op_q;
  logic [22:0]            data_q;
  logic [2*NB_WORD-1:0]   rsp_data_q;
  logic                   accept, lo_cap, hi_cap;

  // rst_done_q keeps ready low during reset and for the edge that releases it
  assign o_req_ready = (state_q == IDLE) && rst_done_q;
  assign accept      = i_req_valid && o_req_ready;
  assign lo_cap      = rd_q && !lo_done_q && (lat_cnt_q == CNT_W'(1));
  assign hi_cap      = rd_q && wide_q && lo_done_q && !hi_done_q && (lat_cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  if (cyc_cnt_q == CNT_W'(1)) state_d = rd_q ? WAIT_LO : GAP;
      WAIT_LO: if (lo_done_q || lo_cap) state_d = wide_q ? WAIT_HI : RESP;
      WAIT_HI: if (hi_done_q || hi_cap) state_d = RESP;
      RESP:    if (i_rsp_ready) state_d = GAP;
      GAP:     if (cyc_cnt_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cyc_cnt_q  <= '0;
      lat_cnt_q  <= '0;
      lo_done_q  <= 1'b0;
      hi_done_q  <= 1'b0;
      rd_q       <= 1'b0;
      wide_q     <= 1'b0;
      rst_done_q <= 1'b0;
      op_q       <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      rst_done_q <= 1'b1;
      state_q    <= state_d;
      if (accept) begin
        op_q       <= i_req_opcode;
        data_q     <= i_req_data;
        rd_q       <= i_req_read;
        wide_q     <= i_req_read & i_req_wide;
        lo_done_q  <= 1'b0;
        hi_done_q  <= 1'b0;
        lat_cnt_q  <= '0;
        rsp_data_q <= '0;
      end else if (state_q == SETUP) begin
        // latency is measured from the edge that raises enable
        lat_cnt_q <= CNT_W'(R_EFF);
      end else if (lo_cap) begin
        lat_cnt_q  <= wide_q ? CNT_W'(H_EFF) : '0;
        lo_done_q  <= 1'b1;
        rsp_data_q <= {{NB_WORD{1'b0}}, i_rsp_word};
      end else if (hi_cap) begin
        lat_cnt_q  <= '0;
        hi_done_q  <= 1'b1;
        rsp_data_q[2*NB_WORD-1:NB_WORD] <= i_rsp_word;
      end else if (lat_cnt_q != '0) begin
        lat_cnt_q <= lat_cnt_q - CNT_W'(1);
      end

      if (state_d == STROBE && state_q != STROBE)
        cyc_cnt_q <= CNT_W'(S_EFF);
      else if (state_d == GAP && state_q != GAP)
        cyc_cnt_q <= CNT_W'(G_EFF);
      else if (cyc_cnt_q != '0)
        cyc_cnt_q <= cyc_cnt_q - CNT_W'(1);
    end
  end

  assign o_cmd_word  = NB_WORD'({op_q, (state_q == STROBE), data_q});
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_data  = rsp_data_q;
  assign o_busy      = (state_q != IDLE);

endmodule
